// File: rtl/spi_master_param.sv
// Parameterised SPI master: one transfer of 1..DATA_W bits with selectable CPOL/CPHA,
// bit order, clock divider and chip select, sequenced IDLE -> SETUP -> SHIFT -> HOLD -> DONE.
module spi_master_param #(
    parameter  int DATA_W = 16,
    parameter  int NUM_CS = 4,
    parameter  int DIV_W  = 8,
    localparam int TS_W   = $clog2(DATA_W) + 1,
    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              t_start,
    input  logic [DATA_W-1:0] d_in,
    input  logic [TS_W-1:0]   t_size,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [CS_W-1:0]   cs_sel,
    output logic [DATA_W-1:0] d_out,
    output logic              read_en,
    output logic              busy,
    output logic [NUM_CS-1:0] cs,
    output logic              spi_clk,
    output logic              mosi,
    input  logic              miso
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]        state_r;
    logic [DIV_W-1:0]  cnt_r;
    logic [DIV_W-1:0]  div_r;
    logic [TS_W:0]     edge_r;
    logic [TS_W-1:0]   n_r;
    logic [DATA_W-1:0] tx_r;
    logic [DATA_W-1:0] rx_r;
    logic              cpol_r;
    logic              cpha_r;
    logic              lsb_r;
    logic              busy_r;
    logic              read_en_r;
    logic [NUM_CS-1:0] cs_r;
    logic              spi_clk_r;
    logic              mosi_r;
    logic [DATA_W-1:0] d_out_r;

    logic [TS_W-1:0]   n_s;
    logic [DATA_W-1:0] aligned_s;
    logic [NUM_CS-1:0] cs_dec_s;
    logic              tick_s;
    logic              lead_s;
    logic              last_s;
    logic [DATA_W-1:0] tx_shift_s;
    logic [DATA_W-1:0] rx_ins_s;
    logic [DATA_W-1:0] rx_final_s;

    // Bit currently presented on the wire for a word aligned to its shift direction
    function automatic logic out_bit(input logic [DATA_W-1:0] word, input logic lsb);
        if (lsb) begin
            out_bit = word[0];
        end else begin
            out_bit = word[DATA_W-1];
        end
    endfunction

    // Request decode: effective length, shift alignment and chip-select pattern
    always_comb begin
        n_s       = t_size;
        aligned_s = d_in;
        cs_dec_s  = {NUM_CS{1'b1}};
        if ((t_size == {TS_W{1'b0}}) || (t_size > TS_W'(DATA_W))) begin
            n_s = TS_W'(DATA_W);
        end else begin
            n_s = t_size;
        end
        // MSB-first words are left-aligned so bit n-1 leaves first from the top
        if (lsb_first) begin
            aligned_s = d_in;
        end else begin
            aligned_s = d_in << (DATA_W - int'(n_s));
        end
        for (int i = 0; i < NUM_CS; i++) begin
            cs_dec_s[i] = (cs_sel != CS_W'(i));
        end
    end

    // Shift-phase helpers derived from the captured configuration
    always_comb begin
        tick_s     = (cnt_r == div_r);
        lead_s     = ~edge_r[0];
        last_s     = (edge_r == ({n_r, 1'b0} - {{TS_W{1'b0}}, 1'b1}));
        tx_shift_s = tx_r;
        rx_ins_s   = rx_r;
        rx_final_s = rx_r;
        if (lsb_r) begin
            tx_shift_s = tx_r >> 1;
            rx_ins_s   = {miso, rx_r[DATA_W-1:1]};
            rx_final_s = rx_r >> (DATA_W - int'(n_r));
        end else begin
            tx_shift_s = tx_r << 1;
            rx_ins_s   = {rx_r[DATA_W-2:0], miso};
            rx_final_s = rx_r;
        end
    end

    // Transfer sequencer and all registered outputs
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {DIV_W{1'b0}};
            div_r     <= {DIV_W{1'b0}};
            edge_r    <= {(TS_W+1){1'b0}};
            n_r       <= {TS_W{1'b0}};
            tx_r      <= {DATA_W{1'b0}};
            rx_r      <= {DATA_W{1'b0}};
            cpol_r    <= 1'b0;
            cpha_r    <= 1'b0;
            lsb_r     <= 1'b0;
            busy_r    <= 1'b0;
            read_en_r <= 1'b0;
            cs_r      <= {NUM_CS{1'b1}};
            spi_clk_r <= 1'b0;
            mosi_r    <= 1'b0;
            d_out_r   <= {DATA_W{1'b0}};
        end else begin
            read_en_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (t_start) begin
                        state_r   <= ST_SETUP;
                        busy_r    <= 1'b1;
                        n_r       <= n_s;
                        div_r     <= clk_div;
                        cpol_r    <= cpol;
                        cpha_r    <= cpha;
                        lsb_r     <= lsb_first;
                        cs_r      <= cs_dec_s;
                        spi_clk_r <= cpol;
                        tx_r      <= aligned_s;
                        rx_r      <= {DATA_W{1'b0}};
                        cnt_r     <= {DIV_W{1'b0}};
                        edge_r    <= {(TS_W+1){1'b0}};
                        // CPHA=1 drives the first bit on the first leading edge instead
                        mosi_r    <= cpha ? 1'b0 : out_bit(aligned_s, lsb_first);
                    end else begin
                        mosi_r <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (tick_s) begin
                        state_r <= ST_SHIFT;
                        cnt_r   <= {DIV_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + DIV_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (tick_s) begin
                        cnt_r     <= {DIV_W{1'b0}};
                        spi_clk_r <= ~spi_clk_r;
                        edge_r    <= edge_r + {{TS_W{1'b0}}, 1'b1};
                        if (lead_s == ~cpha_r) begin
                            rx_r <= rx_ins_s;
                        end else if (lead_s) begin
                            mosi_r <= out_bit(tx_r, lsb_r);
                            tx_r   <= tx_shift_s;
                        end else begin
                            mosi_r <= out_bit(tx_shift_s, lsb_r);
                            tx_r   <= tx_shift_s;
                        end
                        if (last_s) begin
                            state_r <= ST_HOLD;
                        end else begin
                            state_r <= ST_SHIFT;
                        end
                    end else begin
                        cnt_r <= cnt_r + DIV_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (tick_s) begin
                        state_r   <= ST_DONE;
                        cnt_r     <= {DIV_W{1'b0}};
                        cs_r      <= {NUM_CS{1'b1}};
                        d_out_r   <= rx_final_s;
                        read_en_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + DIV_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    mosi_r  <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    cs_r      <= {NUM_CS{1'b1}};
                    spi_clk_r <= cpol_r;
                    mosi_r    <= 1'b0;
                end
            endcase
        end
    end

    assign d_out   = d_out_r;
    assign read_en = read_en_r;
    assign busy    = busy_r;
    assign cs      = cs_r;
    assign spi_clk = spi_clk_r;
    assign mosi    = mosi_r;

endmodule
